// File: rtl/crtc_dma_arb.sv
// CRTC row-buffer DMA / Z80 bus arbiter: BUSRQ/BUSAK handshake, RAM address mux, burst byte check.
// Optional BUSAK timeout abort is built when CRTC_DMA_TIMEOUT_EN is defined.
module crtc_dma_arb #(
  parameter int HOLDOFF   = 4,
  parameter int BURST_LEN = 120,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crtc_busreq,
  output logic        crtc_busack,
  input  logic [16:0] crtc_adr,
  output logic [7:0]  crtc_data,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  input  logic [16:0] cpu_adr,
  output logic [16:0] mem_adr,
  input  logic [7:0]  mem_data,
  output logic        dma_active,
  output logic        burst_err,
  input  logic        err_clr,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, REQ, GRANT, REL, HOLD} state_t;

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_timeout_range
    $error("crtc_dma_arb: TIMEOUT must fit the 10-bit REQ counter");
  end

  state_t        state_q, state_d;
  logic          busak_s1_q, busak_s1_d, busak_s2_q, busak_s2_d;
  logic [16:0]   adr_prev_q, adr_prev_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pend_q, pend_d;
  logic          busrq_n_q, busrq_n_d, busack_q, busack_d, dma_q, dma_d;
  logic          burst_err_q, burst_err_d;
  logic [7:0]    data_q, data_d;
  logic          req_ok;

`ifdef CRTC_DMA_TIMEOUT_EN
  logic [9:0] to_cnt_q, to_cnt_d;
  logic       mask_q, mask_d, timeout_err_q, timeout_err_d;
  // A request that timed out stays ignored until the CRTC drops it.
  assign req_ok      = crtc_busreq & ~mask_q;
  assign timeout_err = timeout_err_q;
`else
  assign req_ok      = crtc_busreq;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    busak_s1_d  = cpu_busak_n;
    busak_s2_d  = busak_s1_q;
    adr_prev_d  = crtc_adr;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    pend_d      = pend_q;
    busrq_n_d   = busrq_n_q;
    busack_d    = busack_q;
    dma_d       = dma_q;
    burst_err_d = burst_err_q & ~err_clr;
    data_d      = mem_data;
`ifdef CRTC_DMA_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    mask_d        = mask_q & crtc_busreq;
    timeout_err_d = timeout_err_q & ~err_clr;
`endif
    case (state_q)
      IDLE: begin
        if (req_ok || pend_q) begin
          state_d   = REQ;
          busrq_n_d = 1'b0;
          pend_d    = 1'b0;
`ifdef CRTC_DMA_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      REQ: begin
        if (!crtc_busreq) begin
          state_d   = REL;
          busrq_n_d = 1'b1;
        end else if (!busak_s2_q) begin
          state_d    = GRANT;
          byte_cnt_d = '0;
          busack_d   = 1'b1;
          dma_d      = 1'b1;
        end
`ifdef CRTC_DMA_TIMEOUT_EN
        else if (to_cnt_q == 10'(TIMEOUT - 1)) begin
          state_d       = REL;
          busrq_n_d     = 1'b1;
          timeout_err_d = 1'b1;
          mask_d        = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 10'd1;
        end
`endif
      end
      GRANT: begin
        if (crtc_adr != adr_prev_q && byte_cnt_q != 8'hFF)
          byte_cnt_d = byte_cnt_q + 8'd1;
        // The check includes an address step seen on the releasing clock.
        if (!crtc_busreq) begin
          state_d   = REL;
          busrq_n_d = 1'b1;
          busack_d  = 1'b0;
          dma_d     = 1'b0;
          if (byte_cnt_d != 8'(BURST_LEN))
            burst_err_d = 1'b1;
        end
      end
      REL: begin
        if (busak_s2_q) begin
          state_d    = HOLD;
          hold_cnt_d = HW'(HOLDOFF);
        end
      end
      HOLD: begin
        if (req_ok)
          pend_d = 1'b1;
        if (hold_cnt_q <= HW'(1)) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busak_s1_q    <= 1'b1;
      busak_s2_q    <= 1'b1;
      adr_prev_q    <= '0;
      byte_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      pend_q        <= 1'b0;
      busrq_n_q     <= 1'b1;
      busack_q      <= 1'b0;
      dma_q         <= 1'b0;
      burst_err_q   <= 1'b0;
      data_q        <= '0;
`ifdef CRTC_DMA_TIMEOUT_EN
      to_cnt_q      <= '0;
      mask_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busak_s1_q    <= busak_s1_d;
      busak_s2_q    <= busak_s2_d;
      adr_prev_q    <= adr_prev_d;
      byte_cnt_q    <= byte_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      pend_q        <= pend_d;
      busrq_n_q     <= busrq_n_d;
      busack_q      <= busack_d;
      dma_q         <= dma_d;
      burst_err_q   <= burst_err_d;
      data_q        <= data_d;
`ifdef CRTC_DMA_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign cpu_busrq_n = busrq_n_q;
  assign crtc_busack = busack_q;
  assign dma_active  = dma_q;
  assign burst_err   = burst_err_q;
  assign crtc_data   = data_q;
  assign mem_adr     = dma_q ? crtc_adr : cpu_adr;

endmodule
